// File: rtl/picosoc_mem_dma_pkg.sv
// Shared types and constants for the PicoSoC memory DMA initiator.
package picosoc_mem_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_GAP_W = 3'd2,
    S_WR    = 3'd3,
    S_GAP_R = 3'd4,
    S_FIN   = 3'd5
  } dma_state_t;

  localparam logic [3:0] WSTRB_RD = 4'b0000;
  localparam logic [3:0] WSTRB_WR = 4'b1111;

endpackage

// File: rtl/picosoc_mem_dma_watchdog.sv
// Request watchdog: counts stalled cycles of one transaction and flags expiry.
module dma_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic resetn,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn || restart) begin
      cnt <= '0;
    end else if (enable && cnt != LIMIT) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Expiry fires on the TIMEOUT-th stalled cycle of the request.
  assign expired = enable && (cnt == LIMIT);

endmodule

// File: rtl/picosoc_mem_dma.sv
// Copy/fill DMA initiator on the PicoSoC native memory bus (valid/ready, word address).
module picosoc_mem_dma
  import picosoc_mem_dma_pkg::*;
#(
  parameter int ADDR_W  = 22,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [31:0]       pattern,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  words_done,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  dma_state_t        state;
  logic [ADDR_W-1:0] src_r, dst_r;
  logic [LEN_W-1:0]  len_r, cnt, cnt_inc;
  logic              mode_r;
  logic [31:0]       pat_r, buf_r;
  logic              wd_expired;

  assign cnt_inc    = cnt + LEN_W'(1);
  assign words_done = cnt;

  // Watchdog is held clear whenever no request is on the bus, so it restarts on each RD/WR entry.
  dma_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .restart (!mem_valid),
    .enable  (mem_valid && !mem_ready),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= WSTRB_RD;
      mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_r  <= src_addr;
            dst_r  <= dst_addr;
            len_r  <= len;
            mode_r <= mode;
            pat_r  <= pattern;
            cnt    <= '0;
            err    <= 1'b0;
            if (len == '0) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              busy      <= 1'b1;
              mem_valid <= 1'b1;
              if (mode) begin
                state     <= S_WR;
                mem_addr  <= dst_addr;
                mem_wstrb <= WSTRB_WR;
                mem_wdata <= pattern;
              end else begin
                state     <= S_RD;
                mem_addr  <= src_addr;
                mem_wstrb <= WSTRB_RD;
              end
            end
          end
        end
        S_RD: begin
          if (mem_ready) begin
            buf_r     <= mem_rdata;
            mem_valid <= 1'b0;
            state     <= S_GAP_W;
          end else if (wd_expired) begin
            mem_valid <= 1'b0;
            err       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_FIN;
          end
        end
        S_GAP_W: begin
          // A fetched word is dropped here if abort is up; it never reaches the bus.
          if (abort) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_FIN;
          end else begin
            mem_valid <= 1'b1;
            mem_addr  <= dst_r + ADDR_W'(cnt);
            mem_wstrb <= WSTRB_WR;
            mem_wdata <= buf_r;
            state     <= S_WR;
          end
        end
        S_WR: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            cnt       <= cnt_inc;
            if (cnt_inc == len_r || abort) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              state <= S_GAP_R;
            end
          end else if (wd_expired) begin
            mem_valid <= 1'b0;
            err       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_FIN;
          end
        end
        S_GAP_R: begin
          if (abort) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_FIN;
          end else if (mode_r) begin
            mem_valid <= 1'b1;
            mem_addr  <= dst_r + ADDR_W'(cnt);
            mem_wstrb <= WSTRB_WR;
            mem_wdata <= pat_r;
            state     <= S_WR;
          end else begin
            mem_valid <= 1'b1;
            mem_addr  <= src_r + ADDR_W'(cnt);
            mem_wstrb <= WSTRB_RD;
            state     <= S_RD;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
